// File: rtl/lsu_mem_arbiter_pkg.sv
// State encoding and shared types for the load/store memory port arbiter.
package lsu_mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_WAIT_LD = 2'd1;
  localparam logic [1:0] ARB_WAIT_ST = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ARB_IDLE,
    S_WAIT_LD = ARB_WAIT_LD,
    S_WAIT_ST = ARB_WAIT_ST
  } arb_state_e;

endpackage

// File: rtl/defines.sv
// Grant encoding shared by the arbiter and its round-robin picker.
`ifndef LSU_MEM_ARBITER_DEFINES_SV
`define LSU_MEM_ARBITER_DEFINES_SV
`define ARB_GRANT_LD 1'b0
`define ARB_GRANT_ST 1'b1
`endif

// File: rtl/lsu_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the channel that did not win last time wins.
`include "defines.sv"

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = 2'b00;
      if (last_grant == `ARB_GRANT_ST) grant[`ARB_GRANT_LD] = 1'b1;
      else                             grant[`ARB_GRANT_ST] = 1'b1;
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one D$/MEM request port between the load and store channels,
// one outstanding operation at a time, with a response watchdog.
`include "defines.sv"

module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int INDEX_W        = 19,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               opload_index_valid,
  input  logic [INDEX_W-1:0] opload_index,
  output logic               opload_index_ready,
  output logic [DATA_W-1:0]  opload_read_data,
  output logic               opload_operation_done,
  input  logic               opstore_index_valid,
  input  logic [INDEX_W-1:0] opstore_index,
  input  logic [DATA_W-1:0]  opstore_write_mask,
  input  logic [DATA_W-1:0]  opstore_write_data,
  output logic               opstore_index_ready,
  output logic               opstore_operation_done,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_is_write,
  output logic [INDEX_W-1:0] mem_req_index,
  output logic [DATA_W-1:0]  mem_req_write_mask,
  output logic [DATA_W-1:0]  mem_req_write_data,
  input  logic               mem_resp_done,
  input  logic [DATA_W-1:0]  mem_resp_read_data,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_spurious
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  arb_state_e      state;
  logic            last_grant;
  logic [TO_W-1:0] wd_cnt;
  logic [1:0]      req, gnt;
  logic            win_st, accept, waiting;

  assign req     = {opstore_index_valid, opload_index_valid};
  assign win_st  = gnt[`ARB_GRANT_ST];
  assign waiting = (state == S_WAIT_LD) || (state == S_WAIT_ST);
  assign busy    = waiting;
  assign accept  = mem_req_valid & mem_req_ready;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .grant      (gnt)
  );

  // Pass-through outputs are gated by reset_n so everything reads 0 during reset.
  always_comb begin
    mem_req_valid          = 1'b0;
    mem_req_is_write       = 1'b0;
    mem_req_index          = '0;
    mem_req_write_mask     = '0;
    mem_req_write_data     = '0;
    opload_index_ready     = 1'b0;
    opstore_index_ready    = 1'b0;
    opload_operation_done  = 1'b0;
    opload_read_data       = '0;
    opstore_operation_done = 1'b0;
    if (reset_n && state == S_IDLE && |req) begin
      mem_req_valid = 1'b1;
      if (win_st) begin
        mem_req_is_write    = 1'b1;
        mem_req_index       = opstore_index;
        mem_req_write_mask  = opstore_write_mask;
        mem_req_write_data  = opstore_write_data;
        opstore_index_ready = mem_req_ready;
      end else begin
        mem_req_index       = opload_index;
        opload_index_ready  = mem_req_ready;
      end
    end
    if (mem_resp_done && state == S_WAIT_LD) begin
      opload_operation_done = 1'b1;
      opload_read_data      = mem_resp_read_data;
    end
    if (mem_resp_done && state == S_WAIT_ST) opstore_operation_done = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      last_grant   <= `ARB_GRANT_ST;
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_resp_done) err_spurious <= 1'b1;
          if (accept) begin
            last_grant <= win_st;
            wd_cnt     <= '0;
            state      <= win_st ? S_WAIT_ST : S_WAIT_LD;
          end
        end
        S_WAIT_LD, S_WAIT_ST: begin
          if (mem_resp_done) begin
            state <= S_IDLE;
          end else begin
            // err_timeout rises on the same edge wd_cnt reaches TO_MAX.
            if (wd_cnt != TO_MAX) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TO_MAX - 1'b1) err_timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter with a short watchdog timeout.
module tb_lsu_mem_arbiter;

  localparam int INDEX_W = 19;
  localparam int DATA_W  = 64;
  localparam int TMO     = 8;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               opload_index_valid;
  logic [INDEX_W-1:0] opload_index;
  logic               opload_index_ready;
  logic [DATA_W-1:0]  opload_read_data;
  logic               opload_operation_done;
  logic               opstore_index_valid;
  logic [INDEX_W-1:0] opstore_index;
  logic [DATA_W-1:0]  opstore_write_mask;
  logic [DATA_W-1:0]  opstore_write_data;
  logic               opstore_index_ready;
  logic               opstore_operation_done;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_is_write;
  logic [INDEX_W-1:0] mem_req_index;
  logic [DATA_W-1:0]  mem_req_write_mask;
  logic [DATA_W-1:0]  mem_req_write_data;
  logic               mem_resp_done;
  logic [DATA_W-1:0]  mem_resp_read_data;
  logic               busy;
  logic               err_timeout;
  logic               err_spurious;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lsu_mem_arbiter #(.INDEX_W(INDEX_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .opload_index_valid(opload_index_valid), .opload_index(opload_index),
    .opload_index_ready(opload_index_ready), .opload_read_data(opload_read_data),
    .opload_operation_done(opload_operation_done),
    .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
    .opstore_write_mask(opstore_write_mask), .opstore_write_data(opstore_write_data),
    .opstore_index_ready(opstore_index_ready), .opstore_operation_done(opstore_operation_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_write(mem_req_is_write), .mem_req_index(mem_req_index),
    .mem_req_write_mask(mem_req_write_mask), .mem_req_write_data(mem_req_write_data),
    .mem_resp_done(mem_resp_done), .mem_resp_read_data(mem_resp_read_data),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven, outputs sampled #1 later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    opload_index_valid = 1'b1; opload_index = 19'h12345;
    opstore_index_valid = 1'b0; opstore_index = '0;
    opstore_write_mask = '0; opstore_write_data = '0;
    mem_req_ready = 1'b1; mem_resp_done = 1'b0; mem_resp_read_data = '0;
    #2;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_ld_ready",  opload_index_ready, 0);
    chk("rst_index",     mem_req_index, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_errs",      {err_timeout, err_spurious}, 0);
    opload_index_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Load-only: accept in cycle 0, done in cycle 3.
    opload_index_valid = 1'b1; opload_index = 19'h12345; mem_req_ready = 1'b1;
    #1;
    chk("ld_req_valid", mem_req_valid, 1);
    chk("ld_is_write",  mem_req_is_write, 0);
    chk("ld_index",     mem_req_index, 19'h12345);
    chk("ld_ready",     {opload_index_ready, opstore_index_ready}, 2'b10);
    chk("ld_mask0",     mem_req_write_mask, 0);
    chk("ld_busy_c0",   busy, 0);
    tick();
    opload_index_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    chk("ld_busy_c1",  busy, 1);
    chk("ld_noreq_c1", mem_req_valid, 0);
    tick(); #1;
    chk("ld_busy_c2", busy, 1);
    chk("ld_nodone_c2", opload_operation_done, 0);
    tick();
    mem_resp_done = 1'b1; mem_resp_read_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    chk("ld_done_c3", opload_operation_done, 1);
    chk("ld_data_c3", opload_read_data, 64'hDEADBEEF_CAFEF00D);
    chk("ld_busy_c3", busy, 1);
    tick();
    mem_resp_done = 1'b0;
    #1;
    chk("ld_idle_c4", busy, 0);
    chk("ld_data_zero", opload_read_data, 0);

    // Store-only.
    opstore_index_valid = 1'b1; opstore_index = 19'h00042;
    opstore_write_mask = 64'h00000000_FFFFFFFF; opstore_write_data = 64'h11;
    mem_req_ready = 1'b1;
    #1;
    chk("st_is_write", mem_req_is_write, 1);
    chk("st_index",    mem_req_index, 19'h00042);
    chk("st_mask",     mem_req_write_mask, 64'h00000000_FFFFFFFF);
    chk("st_data",     mem_req_write_data, 64'h11);
    chk("st_ready",    {opload_index_ready, opstore_index_ready}, 2'b01);
    tick();
    opstore_index_valid = 1'b0;
    mem_resp_done = 1'b1; mem_resp_read_data = 64'h55;
    #1;
    chk("st_done",    {opload_operation_done, opstore_operation_done}, 2'b01);
    chk("st_no_rdata", opload_read_data, 0);
    tick();
    mem_resp_done = 1'b0;

    // Round-robin tie with both held valid; last grant was store.
    opload_index_valid = 1'b1; opstore_index_valid = 1'b1; mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", {opload_index_ready, opstore_index_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      mem_resp_done = 1'b1;
      #1;
      chk("rr_wait_noreq", {mem_req_valid, opload_index_ready, opstore_index_ready}, 3'b000);
      tick();
      mem_resp_done = 1'b0;
    end
    opload_index_valid = 1'b0; opstore_index_valid = 1'b0;

    // Backpressure: load stalled, then store joins; load must still win.
    opload_index_valid = 1'b1; opload_index = 19'h00777; mem_req_ready = 1'b0;
    opstore_index = 19'h00042;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall", {mem_req_valid, opload_index_ready, opstore_index_ready}, 3'b100);
      tick();
    end
    opstore_index_valid = 1'b1;
    #1;
    chk("bp_both_stall", {opload_index_ready, opstore_index_ready}, 2'b00);
    chk("bp_both_index", mem_req_index, 19'h00777);
    tick();
    mem_req_ready = 1'b1;
    #1;
    chk("bp_grant_ld", {opload_index_ready, opstore_index_ready, mem_req_is_write}, 3'b100);
    tick();
    opload_index_valid = 1'b0; opstore_index_valid = 1'b0;
    mem_resp_done = 1'b1;
    #1;
    chk("bp_ld_done", opload_operation_done, 1);
    tick();
    mem_resp_done = 1'b0;

    // Watchdog: err_timeout rises on the 8th edge after accept.
    opload_index_valid = 1'b1; opload_index = 19'h00001; mem_req_ready = 1'b1;
    tick();
    opload_index_valid = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      #1;
      chk("to_not_yet", err_timeout, 0);
      tick();
    end
    tick();
    chk("to_set", err_timeout, 1);
    chk("to_still_busy", busy, 1);
    tick();
    mem_resp_done = 1'b1; mem_resp_read_data = 64'hA5A5;
    #1;
    chk("to_late_done", opload_operation_done, 1);
    chk("to_late_data", opload_read_data, 64'hA5A5);
    tick();
    mem_resp_done = 1'b0;

    // Spurious response while idle.
    #1;
    chk("sp_before", err_spurious, 0);
    mem_resp_done = 1'b1;
    #1;
    chk("sp_no_done", {opload_operation_done, opstore_operation_done}, 2'b00);
    tick();
    mem_resp_done = 1'b0;
    #1;
    chk("sp_set", err_spurious, 1);
    chk("sp_idle", busy, 0);
    chk("sp_to_sticky", err_timeout, 1);

    // Reset during WAIT_ST.
    opstore_index_valid = 1'b1; opstore_index = 19'h00099; mem_req_ready = 1'b1;
    tick();
    #1;
    chk("mr_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy0",  busy, 0);
    chk("mr_req0",   {mem_req_valid, opstore_index_ready, opload_index_ready}, 3'b000);
    chk("mr_errs0",  {err_timeout, err_spurious}, 2'b00);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mr_st_accept", {opstore_index_ready, mem_req_is_write}, 2'b11);
    chk("mr_st_index", mem_req_index, 19'h00099);
    tick();
    opstore_index_valid = 1'b0;
    mem_resp_done = 1'b1;
    #1;
    chk("mr_st_done", opstore_operation_done, 1);
    tick();
    mem_resp_done = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one L1 D$/MEM request port between the backend's load channel (opload) and store channel (opstore).
- Sits between the mem stage and the D$ interface, replacing today's two independent channels with one arbitrated, non-pipelined port.
- Arbitration is round-robin, and only one operation is outstanding at a time.
- A watchdog flags a memory response that never arrives, and any spurious response is also flagged.

Parameters:
- INDEX_W, 19, width of the line index on all channels
- DATA_W, 64, width of read/write data and of the write mask
- TIMEOUT_CYCLES, 1024, cycles spent waiting for a response before err_timeout sets; legal range 2..65535
- TO_W, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- opload_index_valid  in  1  load request valid
- opload_index  in  INDEX_W  load index
- opload_index_ready  out  1  load request accepted
- opload_read_data  out  DATA_W  load data, qualified by opload_operation_done
- opload_operation_done  out  1  single-cycle load completion pulse
- opstore_index_valid  in  1  store request valid
- opstore_index  in  INDEX_W  store index
- opstore_write_mask  in  DATA_W  store write mask
- opstore_write_data  in  DATA_W  store write data
- opstore_index_ready  out  1  store request accepted
- opstore_operation_done  out  1  single-cycle store completion pulse
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts the request
- mem_req_is_write  out  1  1 = store, 0 = load
- mem_req_index  out  INDEX_W  downstream index
- mem_req_write_mask  out  DATA_W  downstream mask; 0 for loads
- mem_req_write_data  out  DATA_W  downstream data; 0 for loads
- mem_resp_done  in  1  single-cycle completion from downstream
- mem_resp_read_data  in  DATA_W  downstream read data
- busy  out  1  an operation is outstanding
- err_timeout  out  1  sticky: a response took too long
- err_spurious  out  1  sticky: mem_resp_done arrived while IDLE

Behaviour:
- States: IDLE, WAIT_LD, WAIT_ST. The state, last_grant, wd_cnt and both err flags are flops; every other output is combinational from them and the inputs.
- Reset (async, active-low):
  - state=IDLE, last_grant=1 (store), wd_cnt=0, err_timeout=0, err_spurious=0.
  - All outputs read 0 during reset.
- Winner selection in IDLE:
  - Only load valid: load wins. Only store valid: store wins.
  - Both valid: the channel not equal to last_grant wins. The first tie after reset therefore goes to load.
- Request forwarding in IDLE:
  - mem_req_valid = opload_index_valid | opstore_index_valid.
  - mem_req_index, mem_req_is_write, mem_req_write_mask and mem_req_write_data are muxed from the winner.
  - The winner's index_ready = mem_req_ready. The loser's ready = 0.
- Winner change while stalled: if mem_req_ready stays low, the winner is re-evaluated every cycle. Requesters keep their valid and payload stable until accepted.
- Accept: on mem_req_valid & mem_req_ready, last_grant <= winner, wd_cnt <= 0, and the next state is WAIT_LD or WAIT_ST.
- In WAIT_LD / WAIT_ST:
  - mem_req_valid=0, both index_ready=0, busy=1.
  - wd_cnt increments every cycle and saturates at TIMEOUT_CYCLES.
- Completion: on mem_resp_done in WAIT_LD or WAIT_ST:
  - The matching operation_done = 1 in the same cycle. In WAIT_LD, opload_read_data = mem_resp_read_data in that cycle.
  - The next state is IDLE. A new request can be accepted the following cycle at the earliest.
  - Minimum occupancy is therefore accept cycle + 1 wait cycle, with done at the earliest in the cycle after accept.
- Outside a load completion, opload_read_data = 0.
- Watchdog: when wd_cnt reaches TIMEOUT_CYCLES while waiting, err_timeout sets.
  - The block stays in WAIT; no abort is implemented.
  - A late mem_resp_done still completes normally.
- Spurious response: mem_resp_done in IDLE sets err_spurious and is otherwise ignored. No operation_done is produced and no state changes.
- Same-cycle events: an accept and a mem_resp_done cannot overlap, since done is only honoured in WAIT and accept only happens in IDLE.
- Error flags clear only on reset.
- Reset mid-operation: the block returns to IDLE and the outstanding operation is dropped. Downstream must also be reset.

Decomposition:
- Shared package defs: localparam state encoding ARB_IDLE=2'd0, ARB_WAIT_LD=2'd1, ARB_WAIT_ST=2'd2.
- Add `define ARB_GRANT_LD 1'b0 / ARB_GRANT_ST 1'b1 to defines.sv.
- Sub-module rr_arb2: a 2-input round-robin picker, purely combinational from (req[1:0], last_grant), returning a one-hot grant.

Test Plan:
- Load-only path:
  - Stimulus: load valid with index 0x12345, mem_req_ready=1; done returned 3 cycles later with data 0xDEADBEEF_CAFEF00D.
  - Response: mem_req_is_write=0 with index 0x12345; opload_index_ready=1 in cycle 0; opload_operation_done and that data in cycle 3; busy for cycles 1–3.
- Store-only path:
  - Stimulus: store valid with index 0x00042, mask 0x00000000_FFFFFFFF, data 0x11.
  - Response: mem_req_is_write=1 with identical mask and data forwarded; opstore_operation_done on mem_resp_done.
- Round-robin tie:
  - Stimulus: load and store both held valid for 4 consecutive operations.
  - Response: grant order is LD, ST, LD, ST.
- Backpressure:
  - Stimulus: load valid, mem_req_ready=0 for 5 cycles, then store also asserts valid, then ready rises.
  - Response: no index_ready during the stall; the grant goes to load (last_grant=ST).
- Timeout and spurious response:
  - Stimulus: TIMEOUT_CYCLES=8, no done after a load accept.
  - Response: err_timeout=1 exactly 8 cycles after accept; a later done still pulses opload_operation_done. A done pulse while IDLE sets err_spurious with no operation_done.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously during WAIT_ST.
  - Response: state=IDLE and all outputs 0 immediately; a store after reset is accepted normally.
